inv_sqrt_arbiter: RTL and testbench

INV_SQRT_ARBITER -- requirements
Module: inv_sqrt_arbiter

---
 rtl/inv_sqrt_arbiter.sv | 155 +++++++++++++++
 tb/tb_inv_sqrt_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sqrt_arbiter.sv
// Round-robin arbiter sharing one fixed-latency inverse-square-root datapath
// among N_REQ requesters, with per-requester credits and in-order result tagging.
module inv_sqrt_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [27*N_REQ-1:0]  i_req_x,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic [26:0]          o_dp_x,
    input  logic [26:0]          i_dp_y,
    output logic [N_REQ-1:0]     o_res_valid,
    output logic [26:0]          o_res_data,
    output logic [2:0]           o_res_id,
    output logic                 o_res_err,
    output logic                 o_busy
);

    localparam int         TAG_W     = 5;
    localparam int         TAG_V     = 4;
    localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);

    function automatic logic operand_illegal(input logic [26:0] x);
        return x[26] | (x[25:18] == 8'd0);
    endfunction

    logic [2:0]       rr_ptr_r;
    logic [2:0]       outstanding_r [N_REQ];
    // Stage 0 is captured alongside o_dp_x so the tail lines up with i_dp_y.
    logic [TAG_W-1:0] tag_r [LATENCY+1];

    logic [N_REQ-1:0] eligible_s;
    logic [N_REQ-1:0] rot_s;
    logic [N_REQ-1:0] grant_s;
    logic [N_REQ-1:0] retire_s;
    logic             grant_any_s;
    logic [2:0]       off_s;
    logic [3:0]       pos_s;
    logic [2:0]       grant_id_s;
    logic [2:0]       next_ptr_s;
    logic [26:0]      grant_x_s;
    logic [TAG_W-1:0] tag_in_s;
    logic [TAG_W-1:0] tag_end_s;

    // Eligibility: operand offered, a credit is free, not in reset.
    always_comb begin
        eligible_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            eligible_s[k] = i_req_valid[k] && (outstanding_r[k] < MAX_OUT_C) && !i_rst;
        end
    end

    // Round-robin pick: rotate so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        rot_s       = N_REQ'({eligible_s, eligible_s} >> rr_ptr_r);
        grant_any_s = 1'b0;
        off_s       = 3'd0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot_s[j]) begin
                grant_any_s = 1'b1;
                off_s       = 3'(j);
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        pos_s       = {1'b0, rr_ptr_r} + {1'b0, off_s};
        grant_id_s  = (pos_s >= 4'(N_REQ)) ? 3'(pos_s - 4'(N_REQ)) : pos_s[2:0];
        next_ptr_s  = (grant_id_s == 3'(N_REQ - 1)) ? 3'd0 : grant_id_s + 3'd1;
        grant_s     = grant_any_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_id_s) : '0;
        o_req_ready = grant_s;
    end

    // Granted operand mux and the tag that travels with it.
    always_comb begin
        grant_x_s = 27'd0;
        for (int k = 0; k < N_REQ; k++) begin
            grant_x_s = grant_x_s | (grant_s[k] ? i_req_x[27*k +: 27] : 27'd0);
        end
        tag_in_s  = {grant_any_s, grant_id_s, grant_any_s & operand_illegal(grant_x_s)};
        tag_end_s = tag_r[LATENCY];
        for (int k = 0; k < N_REQ; k++) begin
            retire_s[k] = tag_end_s[TAG_V] && (tag_end_s[3:1] == 3'(k));
        end
    end

    // Issue register and round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dp_x   <= 27'd0;
            rr_ptr_r <= 3'd0;
        end else begin
            o_dp_x   <= grant_x_s;
            rr_ptr_r <= grant_any_s ? next_ptr_s : rr_ptr_r;
        end
    end

    // Tag shift register mirroring the datapath pipeline.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i <= LATENCY; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            tag_r[0] <= tag_in_s;
            for (int i = 1; i <= LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Per-requester credit counters; a grant and a retire on one edge cancel.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < N_REQ; k++) begin
            if (i_rst) begin
                outstanding_r[k] <= 3'd0;
            end else begin
                case ({grant_s[k], retire_s[k]})
                    2'b10:   outstanding_r[k] <= outstanding_r[k] + 3'd1;
                    2'b01:   outstanding_r[k] <= outstanding_r[k] - 3'd1;
                    default: outstanding_r[k] <= outstanding_r[k];
                endcase
            end
        end
    end

    // Result register: strobe, owner, error flag and masked data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_res_valid <= '0;
            o_res_data  <= 27'd0;
            o_res_id    <= 3'd0;
            o_res_err   <= 1'b0;
        end else begin
            o_res_valid <= retire_s;
            o_res_data  <= tag_end_s[0] ? 27'd0 : i_dp_y;
            o_res_id    <= tag_end_s[3:1];
            o_res_err   <= tag_end_s[0];
        end
    end

    // Busy while any tag is live or any credit is held.
    always_comb begin
        o_busy = 1'b0;
        for (int i = 0; i <= LATENCY; i++) begin
            o_busy = o_busy | tag_r[i][TAG_V];
        end
        for (int k = 0; k < N_REQ; k++) begin
            o_busy = o_busy | (outstanding_r[k] != 3'd0);
        end
    end

endmodule

// File: tb/tb_inv_sqrt_arbiter.sv
// Bench for inv_sqrt_arbiter: directed scenarios plus random traffic checked
// against a queue-based reference model and a real-valued 1/sqrt datapath.
module tb_inv_sqrt_arbiter;

    localparam int NR   = 4;
    localparam int LAT  = 4;
    localparam int MAXO = 2;

    typedef struct {
        int          due;
        int          id;
        logic        err;
        logic [26:0] data;
    } res_t;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [26:0]      xs [NR];
    logic [27*NR-1:0] req_x;
    logic [NR-1:0]    req_ready;
    logic [26:0]      dp_x;
    logic [26:0]      dp_y;
    logic [NR-1:0]    res_valid;
    logic [26:0]      res_data;
    logic [2:0]       res_id;
    logic             res_err;
    logic             busy;

    assign req_x = {xs[3], xs[2], xs[1], xs[0]};

    inv_sqrt_arbiter #(.N_REQ(NR), .LATENCY(LAT), .MAX_OUT(MAXO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_x(req_x),
        .o_req_ready(req_ready), .o_dp_x(dp_x), .i_dp_y(dp_y),
        .o_res_valid(res_valid), .o_res_data(res_data), .o_res_id(res_id),
        .o_res_err(res_err), .o_busy(busy)
    );

    int   n_assert;
    int   n_fail;
    int   cyc;
    int   m_ptr;
    int   m_out [NR];
    res_t q [$];
    int   g_id_q [$];
    int   g_edge_q [$];
    int   r_id_q [$];
    int   r_err_q [$];
    int   r_data_q [$];
    int   r_edge_q [$];
    logic [NR-1:0] cap_rv;

    function automatic real pow2(input int e);
        real p;
        p = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
        else        for (int i = 0; i < -e; i++) p = p / 2.0;
        return p;
    endfunction

    function automatic logic bad_op(input logic [26:0] x);
        return (x[26] == 1'b1) || (x[25:18] == 8'd0);
    endfunction

    function automatic logic [26:0] real_to_fp(input real r);
        int  e;
        int  m;
        real v;
        v = r;
        e = 127;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        m = $rtoi((v - 1.0) * 262144.0 + 0.5);
        if (m >= 262144) begin m = 0; e++; end
        return {1'b0, e[7:0], m[17:0]};
    endfunction

    function automatic logic [26:0] rsqrt(input logic [26:0] x);
        real v;
        if (bad_op(x)) return 27'd0;
        v = (1.0 + real'(x[17:0]) / 262144.0) * pow2(int'(x[25:18]) - 127);
        return real_to_fp(1.0 / $sqrt(v));
    endfunction

    function automatic logic [26:0] rand_x();
        logic       s;
        logic [7:0] e;
        logic [17:0] m;
        s = ($urandom_range(0, 9) == 0);
        e = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 254));
        m = 18'($urandom);
        return {s, e, m};
    endfunction

    // Datapath stand-in: exact LAT-stage delay of 1/sqrt(o_dp_x), never reset.
    logic [26:0] dp_pipe [LAT];
    always @(posedge clk) begin
        dp_pipe[0] <= rsqrt(dp_x);
        for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_y = dp_pipe[LAT-1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check ready before the edge, advance the model, check after.
    task automatic tick();
        int          g;
        int          k;
        logic [NR-1:0] er;
        logic [26:0] gx;
        logic        rst_edge;
        logic        have;
        logic        busy_e;
        res_t        r;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                k = (m_ptr + i) % NR;
                if (g < 0 && req_valid[k] && m_out[k] < MAXO) g = k;
            end
        end
        er = (g >= 0) ? NR'(1 << g) : '0;
        chk("ready", 32'(req_ready), 32'(er));
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                g_id_q.push_back(i);
                g_edge_q.push_back(cyc + 1);
            end
        end
        @(posedge clk);
        cyc++;
        rst_edge = rst;
        gx = 27'd0;
        have = 1'b0;
        if (rst_edge) begin
            q.delete();
            m_ptr = 0;
            for (int i = 0; i < NR; i++) m_out[i] = 0;
        end else begin
            if (g >= 0) begin
                gx = xs[g];
                r.due = cyc + LAT + 1;
                r.id = g;
                r.err = bad_op(gx);
                r.data = r.err ? 27'd0 : rsqrt(gx);
                q.push_back(r);
                m_out[g]++;
                m_ptr = (g + 1) % NR;
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                r = q.pop_front();
                have = 1'b1;
                m_out[r.id]--;
            end
        end
        busy_e = (q.size() != 0);
        for (int i = 0; i < NR; i++) busy_e = busy_e | (m_out[i] != 0);
        #1;
        chk("res_valid", 32'(res_valid), have ? 32'(1 << r.id) : 32'd0);
        if (have) begin
            chk("res_id", 32'(res_id), 32'(r.id));
            chk("res_err", 32'(res_err), 32'(r.err));
            chk("res_data", 32'(res_data), 32'(r.data));
        end
        if (rst_edge) begin
            chk("rst_data", 32'(res_data), 32'd0);
            chk("rst_id", 32'(res_id), 32'd0);
            chk("rst_err", 32'(res_err), 32'd0);
        end
        if (res_valid != '0) begin
            cap_rv = res_valid;
            r_id_q.push_back(int'(res_id));
            r_err_q.push_back(int'(res_err));
            r_data_q.push_back(int'(res_data));
            r_edge_q.push_back(cyc);
        end
        chk("dp_x", 32'(dp_x), 32'(gx));
        chk("busy", 32'(busy), 32'(busy_e));
    endtask

    task automatic clear_logs();
        g_id_q.delete();
        g_edge_q.delete();
        r_id_q.delete();
        r_err_q.delete();
        r_data_q.delete();
        r_edge_q.delete();
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        cyc = 0;
        m_ptr = 0;
        for (int i = 0; i < NR; i++) begin m_out[i] = 0; xs[i] = 27'd0; end
        rst = 1'b1;
        req_valid = '0;
        cap_rv = '0;
        tick();
        tick();
        rst = 1'b0;

        // Single operation: 4.0 from requester 2 returns 0.5.
        clear_logs();
        xs[2] = 27'h2040000;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (LAT + 3) tick();
        chk("single_grants", 32'(g_id_q.size()), 32'd1);
        chk("single_results", 32'(r_id_q.size()), 32'd1);
        if (g_id_q.size() == 1 && r_id_q.size() == 1) begin
            chk("single_gid", 32'(g_id_q[0]), 32'd2);
            chk("single_rv", 32'(cap_rv), 32'b0100);
            chk("single_data", 32'(r_data_q[0]), 32'h1F80000);
            chk("single_err", 32'(r_err_q[0]), 32'd0);
            chk("single_lat", 32'(r_edge_q[0] - g_edge_q[0]), 32'(LAT + 1));
        end

        // Fairness: all hold 1.0 after reset, grants rotate 0,1,2,3,...
        do_reset();
        clear_logs();
        for (int i = 0; i < NR; i++) xs[i] = 27'h1FC0000;
        req_valid = 4'hF;
        repeat (16) tick();
        req_valid = '0;
        repeat (LAT + 4) tick();
        chk("fair_count_ge8", 32'(g_id_q.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < g_id_q.size(); i++) begin
            chk("fair_order", 32'(g_id_q[i]), 32'(i % NR));
            chk("fair_b2b", 32'(g_edge_q[i] - g_edge_q[0]), 32'(i));
        end
        for (int i = 0; i < r_data_q.size(); i++) chk("fair_data", 32'(r_data_q[i]), 32'h1FC0000);

        // Credits: requester 1 alone; third grant waits for the first result.
        do_reset();
        clear_logs();
        xs[1] = 27'h2040000;
        req_valid = 4'b0010;
        repeat (14) tick();
        req_valid = '0;
        repeat (LAT + 4) tick();
        chk("credit_count_ge4", 32'(g_edge_q.size() >= 4), 32'd1);
        if (g_edge_q.size() >= 4 && r_edge_q.size() >= 1) begin
            chk("credit_g1", 32'(g_edge_q[1] - g_edge_q[0]), 32'd1);
            chk("credit_g2", 32'(g_edge_q[2] - g_edge_q[0]), 32'(LAT + 2));
            chk("credit_g2_after_res", 32'(g_edge_q[2] - r_edge_q[0]), 32'd1);
            chk("credit_g3", 32'(g_edge_q[3] - g_edge_q[0]), 32'(LAT + 3));
        end

        // Illegal operands: negative, then zero exponent.
        clear_logs();
        xs[3] = 27'h4000000;
        req_valid = 4'b1000;
        tick();
        xs[3] = 27'h0000123;
        tick();
        req_valid = '0;
        repeat (LAT + 3) tick();
        chk("illegal_results", 32'(r_id_q.size()), 32'd2);
        for (int i = 0; i < 2 && i < r_id_q.size(); i++) begin
            chk("illegal_id", 32'(r_id_q[i]), 32'd3);
            chk("illegal_err", 32'(r_err_q[i]), 32'd1);
            chk("illegal_data", 32'(r_data_q[i]), 32'd0);
        end
        if (r_edge_q.size() == 2) chk("illegal_order", 32'(r_edge_q[1] - r_edge_q[0]), 32'd1);

        // Reset mid-flight: three issues, reset LAT-1 edges after the first.
        clear_logs();
        for (int i = 0; i < NR; i++) xs[i] = 27'h2040000 + 27'(i);
        req_valid = 4'b0111;
        repeat (3) tick();
        req_valid = '0;
        repeat (LAT - 4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (LAT + 4) tick();
        chk("rst_no_results", 32'(r_id_q.size()), 32'd0);
        g_id_q.delete();
        req_valid = 4'hF;
        tick();
        req_valid = '0;
        chk("rst_next_grant_n", 32'(g_id_q.size()), 32'd1);
        if (g_id_q.size() == 1) chk("rst_next_grant", 32'(g_id_q[0]), 32'd0);
        repeat (LAT + 4) tick();

        // Random traffic with occasional resets.
        repeat (400) begin
            req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) xs[i] = rand_x();
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        req_valid = '0;
        repeat (LAT + 4) tick();
        chk("final_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
